// File: rtl/window_averager_pkg.sv
// Shared types and constants for the window averager and its accumulator.
package window_averager_pkg;

    localparam int unsigned SAMPLE_W = 16;
    localparam int unsigned RESULT_W = 32;
    localparam int unsigned MODE_W   = 4;

    localparam logic [MODE_W-1:0] MODE_PASS_IN0 = 4'h0;
    localparam logic [MODE_W-1:0] MODE_PASS_IN1 = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    // One closed window waiting to be handed to the divider
    typedef struct packed {
        logic [SAMPLE_W-1:0] avg_s;
        logic [SAMPLE_W-1:0] avg_r;
        logic [MODE_W-1:0]   mode;
    } window_t;

endpackage

// File: rtl/window_averager_pair_accumulator.sv
// Boxcar accumulator for paired signed/unsigned samples over 2^LOG2N samples.
// Window averages and the close strobe are combinational from the closing sample.
module pair_accumulator
    import window_averager_pkg::*;
#(
    parameter int unsigned LOG2N = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       sample_valid,
    input  logic signed [SAMPLE_W-1:0] sig,
    input  logic        [SAMPLE_W-1:0] ref_amp,
    output logic signed [SAMPLE_W-1:0] avg_s_c,
    output logic        [SAMPLE_W-1:0] avg_r_c,
    output logic                       close_c
);

    localparam int unsigned ACC_W = SAMPLE_W + LOG2N;

    logic signed [ACC_W-1:0] sum_s;
    logic signed [ACC_W-1:0] next_s;
    logic        [ACC_W-1:0] sum_r;
    logic        [ACC_W-1:0] next_r;
    logic        [LOG2N-1:0] cnt;

    // Sums including the current sample, so the closing sample lands in its own window
    always_comb begin
        next_s  = sum_s + ACC_W'(sig);
        next_r  = sum_r + ACC_W'(ref_amp);
        close_c = sample_valid && (cnt == {LOG2N{1'b1}});
        avg_s_c = SAMPLE_W'(next_s >>> LOG2N);
        avg_r_c = SAMPLE_W'(next_r >> LOG2N);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_s <= '0;
            sum_r <= '0;
            cnt   <= '0;
        end else if (sample_valid) begin
            if (close_c) begin
                sum_s <= '0;
                sum_r <= '0;
                cnt   <= '0;
            end else begin
                sum_s <= next_s;
                sum_r <= next_r;
                cnt   <= cnt + LOG2N'(1);
            end
        end
    end

endmodule

// File: rtl/window_averager.sv
// Window averager feeding the lock-in ratio divider, with one-deep pending buffer.
// The amplitude input is named ref_amp because ref is a reserved word.
module window_averager
    import window_averager_pkg::*;
#(
    parameter int unsigned LOG2N = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       sample_valid,
    input  logic signed [SAMPLE_W-1:0] sig,
    input  logic        [SAMPLE_W-1:0] ref_amp,
    input  logic        [MODE_W-1:0]   mode,
    input  logic                       overrun_clr,
    output logic                       div_once,
    input  logic                       div_done,
    output logic        [SAMPLE_W-1:0] div_in0,
    output logic        [SAMPLE_W-1:0] div_in1,
    output logic        [MODE_W-1:0]   div_shift,
    input  logic        [RESULT_W-1:0] div_out,
    output logic        [RESULT_W-1:0] result,
    output logic                       result_valid,
    output logic                       overrun
);

    state_t  state;
    state_t  state_nxt;
    window_t pend_win;
    logic    pend;
    logic    issue_c;
    logic    drop_c;

    logic signed [SAMPLE_W-1:0] avg_s_c;
    logic        [SAMPLE_W-1:0] avg_r_c;
    logic                       close_c;

    pair_accumulator #(
        .LOG2N(LOG2N)
    ) u_acc (
        .clk         (clk),
        .rst         (rst),
        .sample_valid(sample_valid),
        .sig         (sig),
        .ref_amp     (ref_amp),
        .avg_s_c     (avg_s_c),
        .avg_r_c     (avg_r_c),
        .close_c     (close_c)
    );

    // Next-state logic; a window is only dropped if the pending one is not being issued this cycle
    always_comb begin
        state_nxt = state;
        issue_c   = 1'b0;
        drop_c    = 1'b0;
        case (state)
            ST_IDLE:  if (pend) begin
                          state_nxt = ST_ISSUE;
                          issue_c   = 1'b1;
                      end
            ST_ISSUE: state_nxt = ST_WAIT;
            ST_WAIT:  if (div_done) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
        drop_c = close_c && pend && !issue_c;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // Pending buffer: newest closed window wins
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend     <= 1'b0;
            pend_win <= '0;
        end else if (close_c) begin
            pend           <= 1'b1;
            pend_win.avg_s <= avg_s_c;
            pend_win.avg_r <= avg_r_c;
            pend_win.mode  <= mode;
        end else if (issue_c) begin
            pend <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_once     <= 1'b0;
            div_in0      <= '0;
            div_in1      <= '0;
            div_shift    <= '0;
            result       <= '0;
            result_valid <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            div_once     <= (state == ST_ISSUE);
            result_valid <= (state == ST_WAIT) && div_done;
            if (issue_c) begin
                div_in0   <= pend_win.avg_s;
                div_in1   <= pend_win.avg_r;
                div_shift <= pend_win.mode;
            end
            if ((state == ST_WAIT) && div_done) result <= div_out;
            if (drop_c)           overrun <= 1'b1;
            else if (overrun_clr) overrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_window_averager.sv
// Directed, table-driven bench for window_averager with LOG2N=2 and a task-based divider.
module tb_window_averager;

    logic        clk;
    logic        rst;
    logic        sample_valid;
    logic [15:0] sig;
    logic [15:0] ref_amp;
    logic [3:0]  mode;
    logic        overrun_clr;
    logic        div_once;
    logic        div_done;
    logic [15:0] div_in0;
    logic [15:0] div_in1;
    logic [3:0]  div_shift;
    logic [31:0] div_out;
    logic [31:0] result;
    logic        result_valid;
    logic        overrun;

    int checks = 0;
    int errors = 0;

    window_averager #(.LOG2N(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .sample_valid(sample_valid),
        .sig         (sig),
        .ref_amp     (ref_amp),
        .mode        (mode),
        .overrun_clr (overrun_clr),
        .div_once    (div_once),
        .div_done    (div_done),
        .div_in0     (div_in0),
        .div_in1     (div_in1),
        .div_shift   (div_shift),
        .div_out     (div_out),
        .result      (result),
        .result_valid(result_valid),
        .overrun     (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0][15:0] s;
        logic [3:0][15:0] r;
        logic [3:0]       m;
        logic [15:0]      e0;
        logic [15:0]      e1;
        logic [31:0]      res;
        logic [3:0]       lat;
    } vec_t;

    vec_t vecs [5];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_once"},   32'(div_once),     32'd0);
        chk({tag, "_in0"},    32'(div_in0),      32'd0);
        chk({tag, "_in1"},    32'(div_in1),      32'd0);
        chk({tag, "_shift"},  32'(div_shift),    32'd0);
        chk({tag, "_result"}, result,            32'd0);
        chk({tag, "_rv"},     32'(result_valid), 32'd0);
        chk({tag, "_ovr"},    32'(overrun),      32'd0);
    endtask

    // Four samples; optional overrun_clr and div_done asserted with the closing sample
    task automatic send_window(input logic [3:0][15:0] s, input logic [3:0][15:0] r,
                               input logic [3:0] m, input bit clr_last, input bit done_last,
                               input logic [31:0] dout);
        mode = m;
        for (int i = 0; i < 4; i++) begin
            sample_valid = 1'b1;
            sig          = s[i];
            ref_amp      = r[i];
            if (i == 3) begin
                overrun_clr = clr_last;
                if (done_last) begin
                    div_done = 1'b1;
                    div_out  = dout;
                end
            end
            tick();
        end
        sample_valid = 1'b0;
        overrun_clr  = 1'b0;
        div_done     = 1'b0;
    endtask

    // Divider model: called in the cycle div_once is visible; answers lat cycles after sampling it
    task automatic divide(input int lat, input logic [31:0] dout, input string tag);
        tick();
        chk({tag, "_once_pulse"}, 32'(div_once), 32'd0);
        repeat (lat - 1) tick();
        div_done = 1'b1;
        div_out  = dout;
        tick();
        div_done = 1'b0;
        chk({tag, "_rv"},     32'(result_valid), 32'd1);
        chk({tag, "_result"}, result,            dout);
        tick();
        chk({tag, "_rv_off"}, 32'(result_valid), 32'd0);
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        send_window(v.s, v.r, v.m, 1'b0, 1'b0, 32'd0);
        chk({tag, "_once_early"}, 32'(div_once), 32'd0);
        tick();
        chk({tag, "_once_e1"}, 32'(div_once), 32'd0);
        tick();
        chk({tag, "_once"},  32'(div_once),  32'd1);
        chk({tag, "_in0"},   32'(div_in0),   32'(v.e0));
        chk({tag, "_in1"},   32'(div_in1),   32'(v.e1));
        chk({tag, "_shift"}, 32'(div_shift), 32'(v.m));
        divide(int'(v.lat), v.res, tag);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{s: {4{16'd100}}, r: {4{16'd200}}, m: 4'd3,
                    e0: 16'd100, e1: 16'd200, res: 32'h0000_1234, lat: 4'd7};
        vecs[1] = '{s: {16'hFFFB, 16'hFFFC, 16'hFFFC, 16'hFFFC}, r: {16'd5, 16'd3, 16'd2, 16'd1},
                    m: 4'h0, e0: 16'hFFFB, e1: 16'd2, res: 32'hCAFE_0001, lat: 4'd1};
        vecs[2] = '{s: {4{16'h7FFF}}, r: {4{16'hFFFF}}, m: 4'hF,
                    e0: 16'h7FFF, e1: 16'hFFFF, res: 32'h0000_FFFF, lat: 4'd1};
        vecs[3] = '{s: {16'hFFFF, 16'd0, 16'd0, 16'd0}, r: {16'd3, 16'd0, 16'd0, 16'd0},
                    m: 4'd7, e0: 16'hFFFF, e1: 16'd0, res: 32'h8765_4321, lat: 4'd7};
        vecs[4] = '{s: {4{16'h8000}}, r: {16'd1, 16'd1, 16'd1, 16'd0}, m: 4'd5,
                    e0: 16'h8000, e1: 16'd0, res: 32'h0BAD_F00D, lat: 4'd2};

        rst          = 1'b1;
        sample_valid = 1'b0;
        sig          = '0;
        ref_amp      = '0;
        mode         = '0;
        overrun_clr  = 1'b0;
        div_done     = 1'b0;
        div_out      = '0;
        tick();
        tick();
        chk_all_zero("reset");
        rst = 1'b0;
        tick();

        for (int i = 0; i < 5; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Three windows against a stalled divider: second buffered, third overwrites it
        send_window({4{16'd1}}, {4{16'd10}}, 4'd1, 1'b0, 1'b0, 32'd0);
        tick();
        tick();
        chk("ovr_w1_once", 32'(div_once), 32'd1);
        chk("ovr_w1_in0",  32'(div_in0),  32'd1);
        send_window({4{16'd2}}, {4{16'd20}}, 4'd2, 1'b0, 1'b0, 32'd0);
        chk("ovr_w2_none", 32'(overrun), 32'd0);
        send_window({4{16'd3}}, {4{16'd30}}, 4'd4, 1'b1, 1'b0, 32'd0);
        chk("ovr_set_beats_clr", 32'(overrun), 32'd1);
        chk("ovr_in0_held",      32'(div_in0), 32'd1);
        overrun_clr = 1'b1;
        tick();
        overrun_clr = 1'b0;
        chk("ovr_cleared", 32'(overrun), 32'd0);
        div_done = 1'b1;
        div_out  = 32'h0000_AAAA;
        tick();
        div_done = 1'b0;
        chk("ovr_w1_rv",     32'(result_valid), 32'd1);
        chk("ovr_w1_result", result,            32'h0000_AAAA);
        tick();
        chk("ovr_w3_in0",   32'(div_in0),   32'd3);
        chk("ovr_w3_in1",   32'(div_in1),   32'd30);
        chk("ovr_w3_shift", 32'(div_shift), 32'd4);
        chk("ovr_w3_early", 32'(div_once),  32'd0);
        tick();
        chk("ovr_w3_once", 32'(div_once), 32'd1);
        divide(3, 32'h0000_BBBB, "ovr_w3");
        chk("ovr_stays_clear", 32'(overrun), 32'd0);

        // Window close coinciding with div_done of the previous divide
        send_window({4{16'd20}}, {4{16'd40}}, 4'd2, 1'b0, 1'b0, 32'd0);
        tick();
        tick();
        chk("coin_wa_once", 32'(div_once), 32'd1);
        send_window({4{16'hFFF8}}, {4{16'd7}}, 4'd6, 1'b0, 1'b1, 32'h0000_5555);
        chk("coin_rv",     32'(result_valid), 32'd1);
        chk("coin_result", result,            32'h0000_5555);
        chk("coin_ovr",    32'(overrun),      32'd0);
        tick();
        chk("coin_once_e1", 32'(div_once),     32'd0);
        chk("coin_rv_off",  32'(result_valid), 32'd0);
        tick();
        chk("coin_once",  32'(div_once),  32'd1);
        chk("coin_in0",   32'(div_in0),   32'h0000_FFF8);
        chk("coin_in1",   32'(div_in1),   32'd7);
        chk("coin_shift", 32'(div_shift), 32'd6);
        chk("coin_ovr2",  32'(overrun),   32'd0);
        divide(1, 32'h0000_6666, "coin_wb");

        // Reset while waiting on the divider abandons that divide
        send_window({4{16'd9}}, {4{16'd9}}, 4'd9, 1'b0, 1'b0, 32'd0);
        tick();
        tick();
        chk("rstw_once", 32'(div_once), 32'd1);
        tick();
        rst = 1'b1;
        #1;
        chk_all_zero("rst_wait");
        tick();
        rst = 1'b0;
        div_done = 1'b1;
        div_out  = 32'h0000_DEAD;
        tick();
        div_done = 1'b0;
        chk("late_done_rv",     32'(result_valid), 32'd0);
        chk("late_done_result", result,            32'd0);
        tick();
        run_vec(vecs[0], "post_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
